// File: rtl/foobar_event_queue.sv
// foobar_event_queue
// Timestamps foo/bar strobe events and queues them in a small FIFO that
// drains through a valid/ready port. Events that arrive while the FIFO is
// full and not being popped are dropped and reported through a sticky
// overflow flag and a saturating drop counter.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-low reset
//   en         - enable: advances the timestamp and allows capture
//   foo, bar   - event strobes
//   out_valid  - head entry valid
//   out_ready  - consumer accepts the head entry
//   out_data   - head entry {foo, bar, timestamp}; 0 when empty
//   level      - occupancy, 0..DEPTH
//   overflow   - sticky, set on any dropped event
//   drop_count - dropped event count, saturates at 255
module foobar_event_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TS_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     foo,
    input  logic                     bar,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TS_W+1:0]          out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [7:0]               drop_count
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned LVL_W  = PTR_W + 1;
    localparam int unsigned ENT_W  = TS_W + 2;
    localparam int unsigned DROP_W = 8;

    logic [TS_W-1:0]   ts_q, ts_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic [ENT_W-1:0]  mem_q [DEPTH];

    logic push_req;
    logic empty;
    logic full;
    logic pop;
    logic push_acc;
    logic drop;

    // Occupancy decode and handshake qualification
    assign push_req = en & (foo | bar);
    assign empty    = (level_q == LVL_W'(0));
    assign full     = (level_q == LVL_W'(DEPTH));
    assign pop      = ~empty & out_ready;
    // A full FIFO still accepts a push when the head is leaving this cycle
    assign push_acc = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    // Next-state logic
    always_comb begin
        ts_d       = ts_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;

        if (en) begin
            ts_d = ts_q + TS_W'(1);
        end
        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push_acc, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        if (drop) begin
            overflow_d = 1'b1;
            if (drop_q != {DROP_W{1'b1}}) begin
                drop_d = drop_q + DROP_W'(1);
            end
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            ts_q       <= ts_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    // Entry storage; contents are only visible through the empty gate
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_q[wr_ptr_q] <= {foo, bar, ts_q};
        end
    end

    assign out_valid  = ~empty;
    assign out_data   = empty ? ENT_W'(0) : mem_q[rd_ptr_q];
    assign level      = level_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule

// File: doc/foobar_event_queue.md
# foobar_event_queue

Downstream consumer of the foobar counter's `foo`/`bar` strobes. Each cycle in which either strobe is high, the block tags the strobe pair with an 8-bit cycle timestamp and queues it in a small FIFO. The FIFO drains through a valid/ready interface to the logging/readout stage. Overflow is reported with a sticky flag and a saturating drop counter, so that no event loss is silent.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `TS_W`, 8: timestamp width in bits.

Ports:
- `clk`  in  1: single clock; all logic on rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `en`  in  1: same enable that drives the foobar counter; gates timestamp advance and event capture.
- `foo`  in  1: foo strobe from the foobar counter.
- `bar`  in  1: bar strobe from the foobar counter.
- `out_valid`  out  1: FIFO head entry is valid.
- `out_ready`  in  1: consumer accepts the head entry.
- `out_data`  out  TS_W+2: head entry, {foo, bar, timestamp[TS_W-1:0]}.
- `level`  out  $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `overflow`  out  1: sticky; set when any event is dropped.
- `drop_count`  out  8: number of dropped events, saturating.

## Operation
- Reset (`rst`=0, asynchronous) values: timestamp 0, read/write pointers 0, `level` 0, `out_valid` 0, `out_data` 0, `overflow` 0, `drop_count` 0.
- Timestamp:
  - Increments by 1 on each edge with `en`=1.
  - Wraps from 2^TS_W-1 to 0.
  - Holds while `en`=0.
- Capture (push request):
  - Condition: `en`=1 and (`foo` | `bar`).
  - Entry = {foo, bar, timestamp value before this edge's increment}.
  - `foo`=`bar`=1 in the same cycle produces one entry with both bits set, not two entries.
- Pop: occurs when `out_valid`=1 and `out_ready`=1 at the edge.
  - Pops are independent of `en`; the FIFO keeps draining while `en`=0.
- Occupancy states, derived from `level`:
  - EMPTY (0): `out_valid`=0, `out_data`=0. Pop is impossible.
  - PARTIAL (1..DEPTH-1): push and pop both accepted, singly or together.
  - FULL (DEPTH):
    - Push without a pop in the same cycle is dropped: `overflow`←1, `drop_count`←min(`drop_count`+1, 255), FIFO unchanged.
    - Push with a simultaneous pop is accepted; `level` stays at DEPTH.
- Simultaneous push and pop in PARTIAL: `level` is unchanged, both pointers advance.
- Push into EMPTY: no fall-through. The entry appears at the output only after the write edge.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. `level` is tracked in a separate counter, not derived from the pointers.
- `overflow` clears only on reset. `drop_count` holds at 255 once reached.
- `out_data` is held stable while `out_valid`=1 and `out_ready`=0. The consumer may stall indefinitely.
- Reset asserted mid-operation discards all queued entries immediately. Outputs return to their reset values without waiting for a clock edge.

## Timing
- Capture latency: an event sampled at edge N gives `out_valid`=1 with that entry on `out_data` after edge N, provided the FIFO was empty. Effective latency is 1 cycle.
- Throughput: one push and one pop per cycle. With `out_ready` held at 1, the FIFO never grows beyond 1 entry.
- Output timing:
  - `out_valid`, `level`, `overflow` and `drop_count` are registered or derived from registers only.
  - `out_data` is a registered-array read at the read pointer, gated to 0 when EMPTY.
  - No output depends combinationally on `out_ready`, `foo`, `bar` or `en`.
- The first edge after `rst` deasserts is a normal operating edge.

## Test plan
- Reset, then `en`=1, `out_ready`=1, `foo` pulse at timestamp 3 → `out_data`={1,0,8'd3} with `out_valid`=1 for exactly one cycle, `level` returns to 0.
- `foo`=`bar`=1 together at timestamp 15 → a single entry {1,1,8'd15}; `level` peaks at 1, not 2.
- `out_ready`=0, 6 events at timestamps 10..15 with DEPTH=4 → `level`=4, `overflow`=1, `drop_count`=2. Then `out_ready`=1 → entries drain in order, timestamps 10, 11, 12, 13.
- FULL with push and pop in the same cycle → `level` stays at 4, `drop_count` unchanged, new entry is last in the drain order.
- `en` toggled low for 5 cycles with strobes active → no captures, timestamp frozen; after `en` returns high, the next entry's timestamp continues from the frozen value. Separately, 300 dropped events → `drop_count`=255.
- Timestamp wrap: run 260 enabled cycles with strobes at cycles 254, 255, 256 → timestamps 254, 255, 0. Assert `rst` low mid-drain → `out_valid`, `level` go to 0 immediately, with no clock edge needed.
